mdu: RTL
========

# mdu

Multi-cycle multiply/divide unit for the pipelined MIPS core, the parametrised successor to the single-cycle ALU. It sits beside the ALU in the EX stage and owns the HI/LO register pair. It executes multiply, divide and multiply-accumulate operations with fixed, parameter-set latencies, and exposes a `busy` flag that the hazard unit uses to stall dependent MDU instructions.

## Interface
- `WIDTH`, 32, operand and HI/LO width in bits
- `MULT_CYCLES`, 5, busy cycles for the MULT/MULTU/MADD/MADDU/MSUB/MSUBU class (>=1)
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU (>=1)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `A`  in  WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO source)
- `B`  in  WIDTH  operand rt (divisor / multiplier)
- `MDUctr`  in  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 13-15 behave as NOP
- `start`  in  1  issue strobe; qualifies MDUctr codes 1-6 and 9-12
- `busy`  out  1  registered; high while an operation is in flight
- `HI`  out  WIDTH  architectural HI register
- `LO`  out  WIDTH  architectural LO register
- `Output`  out  WIDTH  combinational read: HI when MDUctr=7, LO when MDUctr=8, else 0

## Operation
- States: IDLE (busy=0) and RUN (busy=1, down-counter `cnt`).
- Accept: at a rising edge with `start=1`, `busy=0` and a code from 1-4 or 9-12, the unit:
  - latches A, B and the op;
  - loads `cnt` with MULT_CYCLES or DIV_CYCLES;
  - sets busy=1 and enters RUN.
- RUN: `cnt` decrements each edge. On the edge where `cnt==1`, the unit writes HI/LO, clears busy and returns to IDLE.
- Ignored commands: `start` while busy=1 is ignored, with no queueing. This includes MTHI and MTLO.
- MTHI/MTLO: at an edge with `start=1`, `busy=0` and MDUctr=5 (or 6), HI (or LO) takes A in that edge. The other register is unchanged and busy stays 0.
- Result rules, with P the 2*WIDTH product of the latched operands:
  - MULT: signed product; {HI,LO} = P.
  - MULTU: unsigned product; {HI,LO} = P.
  - MADD/MADDU: {HI,LO} = {HI,LO} + P, using the signed or unsigned product as for MULT/MULTU. HI/LO are sampled at completion, modulo 2^(2*WIDTH).
  - MSUB/MSUBU: {HI,LO} = {HI,LO} - P, same sampling and wrap rule.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend.
- Division by zero: the unit still runs the full DIV_CYCLES, and HI/LO remain unchanged.
- Signed DIV of most-negative by -1: LO = most-negative value, HI = 0.
- `Output` depends only on MDUctr, HI and LO. An MFHI/MFLO while busy returns the stale value; preventing that is the stall logic's job.

## Timing
- Reset values: busy=0, HI=0, LO=0, `cnt`=0, latched operands=0, state IDLE. `Output`=0 unless MDUctr=7/8, in which case it reads the reset HI/LO of 0.
- Busy duration: issue at edge t gives busy=1 from just after edge t through edge t+N, where N is the op's latency parameter. HI/LO carry the new value after edge t+N, where busy also falls. Busy is therefore high for exactly N cycles.
- Back-to-back issue: a new `start` is accepted at edge t+N+1 at the earliest. A start presented at edge t+N itself sees busy=1 and is dropped.
- Reset mid-operation: an operation in RUN is aborted at the reset edge. HI/LO are set to 0 and no late write-back occurs.
- Reset priority: `reset` has priority over `start` at the same edge.
- Latency 1: with MULT_CYCLES=1, busy is high for one cycle and HI/LO update at the next edge.

## Test plan
- MULT, A=0xFFFFFFFF, B=0x00000002 → busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; the same operands with MULTU → HI=0x00000001, LO=0xFFFFFFFE.
- DIV, A=0xFFFFFFF9 (-7), B=0x00000002 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU of 7 by 2 → LO=3, HI=1.
- MTHI 0x12345678, then DIV by B=0 → HI stays 0x12345678, LO stays 0 after 10 busy cycles; MFLO gives Output=0.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU A=1, B=1 → HI=0x00000001, LO=0x00000000; then MSUB A=1, B=1 → HI=0x00000000, LO=0xFFFFFFFF.
- MULT issued, then `start` with MTLO 0xAAAA at busy cycle 2 → the MTLO is ignored and the final LO is the product only.
- DIV issued, `reset` asserted at busy cycle 4 → at the next edge busy=0, HI=LO=0, and HI/LO do not change at the original completion edge.

Source files
------------

// File: rtl/mdu_if.sv
// Bus between the EX stage and the multiply/divide unit: operands, opcode,
// issue strobe, and the HI/LO/busy/read-back signals returned to the core.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       MDUctr;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] Output;

  modport master (
    output A, B, MDUctr, start,
    input  busy, HI, LO, Output
  );

  modport slave (
    input  A, B, MDUctr, start,
    output busy, HI, LO, Output
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide/multiply-accumulate unit that owns HI/LO.
// Results appear after a fixed latency; busy covers the whole flight time.
module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_e           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] a_q, b_q, a_n, b_n;
  logic [WIDTH-1:0] hi, lo, hi_n, lo_n;
  op_e              op_q, op_n;

  // Products are taken modulo 2^(2*WIDTH), so the signed one can use
  // sign-extended operands in a plain unsigned multiply.
  logic [2*WIDTH-1:0] prod_s, prod_u;
  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Signed division through magnitudes: avoids the MIN/-1 overflow case and
  // gives truncation toward zero with the remainder following the dividend.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  assign a_neg  = (op_q == OP_DIV) && a_q[WIDTH-1];
  assign b_neg  = (op_q == OP_DIV) && b_q[WIDTH-1];
  assign a_mag  = a_neg ? -a_q : a_q;
  assign b_mag  = b_neg ? -b_q : b_q;
  assign b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem    = a_neg ? -r_mag : r_mag;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves
    // one unassigned, which would infer a latch.
    state_n = state;
    cnt_n   = cnt;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    hi_n    = hi;
    lo_n    = lo;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.MDUctr inside {[4'd1:4'd4], [4'd9:4'd12]}) begin
            a_n     = bus.A;
            b_n     = bus.B;
            op_n    = op_e'(bus.MDUctr);
            cnt_n   = (bus.MDUctr inside {OP_DIV, OP_DIVU}) ? CW'(DIV_CYCLES)
                                                            : CW'(MULT_CYCLES);
            state_n = RUN;
          end else if (bus.MDUctr == OP_MTHI) begin
            hi_n = bus.A;
          end else if (bus.MDUctr == OP_MTLO) begin
            lo_n = bus.A;
          end
        end
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          case (op_q)
            OP_MULT:  {hi_n, lo_n} = prod_s;
            OP_MULTU: {hi_n, lo_n} = prod_u;
            OP_MADD:  {hi_n, lo_n} = {hi, lo} + prod_s;
            OP_MADDU: {hi_n, lo_n} = {hi, lo} + prod_u;
            OP_MSUB:  {hi_n, lo_n} = {hi, lo} - prod_s;
            OP_MSUBU: {hi_n, lo_n} = {hi, lo} - prod_u;
            OP_DIV, OP_DIVU: begin
              if (b_q != '0) begin
                hi_n = rem;
                lo_n = quo;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_NOP;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      a_q   <= a_n;
      b_q   <= b_n;
      op_q  <= op_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.HI   = hi;
  assign bus.LO   = lo;

  always_comb begin
    case (bus.MDUctr)
      OP_MFHI: bus.Output = hi;
      OP_MFLO: bus.Output = lo;
      default: bus.Output = '0;
    endcase
  end

endmodule
